// File: rtl/product_accumulator.sv
// Sums N signed 8-bit products into a block result, presented with a valid/ready handshake.
// Latency: sum_valid 1 cycle after the N-th accept. Backpressure: p_ready low while the result waits.
// Optional build macro SATURATE_EN: overflowing additions clamp instead of wrapping.
module product_accumulator #(
   parameter int N     = 4,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             p_valid,
   input  logic [7:0]       p,
   output logic             p_ready,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {ACC, OUT} state_t;

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] acc, acc_nxt;
   logic signed [ACC_W-1:0] p_ext, add_res, add_val;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic                    ovf_q, ovf_nxt, add_ovf;
   logic [1:0]              rst_sync;
   logic                    arst_n;

   // Assert immediately, release only after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign arst_n = rst_sync[1];

   assign p_ext   = ACC_W'($signed(p));
   assign add_res = acc + p_ext;
   // Signed overflow: operands share a sign that the result does not.
   assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (add_res[ACC_W-1] != acc[ACC_W-1]);

`ifdef SATURATE_EN
   assign add_val = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : add_res;
`else
   assign add_val = add_res;
`endif

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf_q;
      if (clr) begin
         state_nxt = ACC;
         acc_nxt   = '0;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (p_valid) begin
                  acc_nxt = add_val;
                  ovf_nxt = ovf_q | add_ovf;
                  if (cnt == LAST) begin
                     state_nxt = OUT;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
            OUT: begin
               if (sum_ready) begin
                  state_nxt = ACC;
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
                  ovf_nxt   = 1'b0;
               end
            end
            default: state_nxt = ACC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= ACC;
         acc   <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ovf_q <= ovf_nxt;
      end
   end

   assign p_ready   = (state == ACC);
   assign sum_valid = (state == OUT);
   assign sum       = acc;
   assign ovf       = ovf_q;

`ifndef SATURATE_EN
   // Clamp constants exist only for the saturating build.
   logic unused_clamp;
   assign unused_clamp = ^{ACC_MAX, ACC_MIN};
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus a randomized run against an integer-arithmetic model.
module tb_product_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr, p_valid, sum_ready;
   logic [7:0]  p;
   logic        p_ready, sum_valid, ovf;
   logic [11:0] sum;

   logic        pv2;
   logic [7:0]  p2;
   logic        p_ready2, sum_valid2, ovf2;
   logic [7:0]  sum2;

   int total = 0;
   int bad   = 0;

   int m_acc;
   bit m_ovf;
   int m_cnt;
   bit m_out;

   always #5 clk = ~clk;

   product_accumulator #(.N(4), .ACC_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .p_valid(p_valid), .p(p),
      .p_ready(p_ready), .sum_valid(sum_valid), .sum_ready(sum_ready),
      .sum(sum), .ovf(ovf)
   );

   product_accumulator #(.N(2), .ACC_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .p_valid(pv2), .p(p2),
      .p_ready(p_ready2), .sum_valid(sum_valid2), .sum_ready(1'b0),
      .sum(sum2), .ovf(ovf2)
   );

   // Exact integer sum, then fold back into a w-bit signed range.
   function automatic int model_add(input int a, input int b, input int w, output bit o);
      int mx = (1 << (w - 1)) - 1;
      int mn = -(1 << (w - 1));
      int t  = a + b;
      o = (t > mx) || (t < mn);
`ifdef SATURATE_EN
      if (t > mx) t = mx;
      else if (t < mn) t = mn;
`else
      if (t > mx) t = t - (1 << w);
      else if (t < mn) t = t + (1 << w);
`endif
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 0; p_valid = 0; p = 0; sum_ready = 0; pv2 = 0; p2 = 0;
      rst_n = 0;
      repeat (2) step();
      rst_n = 1;
      repeat (3) step();
   endtask

   task automatic test_reset();
      clr = 0; p_valid = 0; p = 0; sum_ready = 0; pv2 = 0; p2 = 0;
      rst_n = 0;
      #3;
      total++;
      if ({p_ready, sum_valid, sum, ovf} !== {1'b1, 1'b0, 12'h000, 1'b0}) begin
         bad++;
         $display("FAIL reset_dut1: got rdy=%b vld=%b sum=%h ovf=%b, want 1 0 000 0", p_ready, sum_valid, sum, ovf);
      end
      total++;
      if ({p_ready2, sum_valid2, sum2, ovf2} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL reset_dut2: got rdy=%b vld=%b sum=%h ovf=%b, want 1 0 00 0", p_ready2, sum_valid2, sum2, ovf2);
      end
      do_reset();
   endtask

   task automatic test_basic();
      int prods[4] = '{-25, 15, 1, -4};
      do_reset();
      p_valid = 1;
      for (int i = 0; i < 4; i++) begin
         p = 8'(prods[i]);
         step();
         if (i == 2) begin
            total++;
            if (sum_valid !== 1'b0 || sum !== 12'(-9)) begin
               bad++;
               $display("FAIL basic_running: got vld=%b sum=%h, want 0 %h", sum_valid, sum, 12'(-9));
            end
         end
      end
      p_valid = 0;
      total++;
      if ({sum_valid, p_ready, sum, ovf} !== {1'b1, 1'b0, 12'hFF3, 1'b0}) begin
         bad++;
         $display("FAIL basic_result: got vld=%b rdy=%b sum=%h ovf=%b, want 1 0 ff3 0", sum_valid, p_ready, sum, ovf);
      end
   endtask

   task automatic test_stall();
      test_basic();
      sum_ready = 0;
      for (int c = 0; c < 3; c++) begin
         p_valid = 1; p = 8'd7;
         step();
         total++;
         if ({sum_valid, p_ready, sum, ovf} !== {1'b1, 1'b0, 12'hFF3, 1'b0}) begin
            bad++;
            $display("FAIL stall_hold%0d: got vld=%b rdy=%b sum=%h ovf=%b, want 1 0 ff3 0", c, sum_valid, p_ready, sum, ovf);
         end
      end
      p_valid = 0; sum_ready = 1;
      step();
      sum_ready = 0;
      total++;
      if ({sum_valid, p_ready, sum, ovf} !== {1'b0, 1'b1, 12'h000, 1'b0}) begin
         bad++;
         $display("FAIL stall_release: got vld=%b rdy=%b sum=%h ovf=%b, want 0 1 000 0", sum_valid, p_ready, sum, ovf);
      end
      p_valid = 1; p = 8'd3;
      step();
      p_valid = 0;
      total++;
      if (sum !== 12'h003) begin
         bad++;
         $display("FAIL stall_next_block: got sum=%h, want 003", sum);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_sum;
`ifdef SATURATE_EN
      exp_sum = 8'h7F;
`else
      exp_sum = 8'hC8;
`endif
      do_reset();
      pv2 = 1; p2 = 8'd100;
      step();
      total++;
      if (sum2 !== 8'd100 || ovf2 !== 1'b0) begin
         bad++;
         $display("FAIL ovf_first: got sum=%h ovf=%b, want 64 0", sum2, ovf2);
      end
      step();
      pv2 = 0;
      total++;
      if ({sum_valid2, sum2, ovf2} !== {1'b1, exp_sum, 1'b1}) begin
         bad++;
         $display("FAIL ovf_result: got vld=%b sum=%h ovf=%b, want 1 %h 1", sum_valid2, sum2, ovf2, exp_sum);
      end
   endtask

   task automatic test_clr();
      do_reset();
      p_valid = 1;
      p = 8'd9; step();
      p = 8'd1; step();
      clr = 1; p = 8'd5; step();
      clr = 0; p_valid = 0;
      total++;
      if ({sum_valid, p_ready, sum, ovf} !== {1'b0, 1'b1, 12'h000, 1'b0}) begin
         bad++;
         $display("FAIL clr_cleared: got vld=%b rdy=%b sum=%h ovf=%b, want 0 1 000 0", sum_valid, p_ready, sum, ovf);
      end
      p_valid = 1; p = 8'd1;
      repeat (3) step();
      total++;
      if (sum_valid !== 1'b0 || sum !== 12'd3) begin
         bad++;
         $display("FAIL clr_count_restart: got vld=%b sum=%h, want 0 003", sum_valid, sum);
      end
      step();
      p_valid = 0;
      total++;
      if (sum_valid !== 1'b1 || sum !== 12'd4) begin
         bad++;
         $display("FAIL clr_block: got vld=%b sum=%h, want 1 004", sum_valid, sum);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      p_valid = 1; p = 8'd1;
      repeat (3) step();
      total++;
      if (sum !== 12'd3) begin
         bad++;
         $display("FAIL areset_pre: got sum=%h, want 003", sum);
      end
      #3 rst_n = 0;
      #1;
      total++;
      if ({sum_valid, p_ready, sum, ovf} !== {1'b0, 1'b1, 12'h000, 1'b0}) begin
         bad++;
         $display("FAIL areset_immediate: got vld=%b rdy=%b sum=%h ovf=%b, want 0 1 000 0", sum_valid, p_ready, sum, ovf);
      end
      p_valid = 0;
      step();
      rst_n = 1;
      repeat (3) step();
      p_valid = 1;
      repeat (4) step();
      p_valid = 0;
      total++;
      if (sum_valid !== 1'b1 || sum !== 12'd4) begin
         bad++;
         $display("FAIL areset_block: got vld=%b sum=%h, want 1 004", sum_valid, sum);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      sum_ready = 1; p_valid = 1;
      for (int c = 0; c < 15; c++) begin
         int ph = c % 5;
         p = (ph % 2 == 0) ? 8'd1 : 8'hFF;
         step();
         total++;
         if ({sum_valid, p_ready} !== {ph == 3, ph != 3} || (ph == 3 && sum !== 12'h000)) begin
            bad++;
            $display("FAIL b2b_cycle%0d: got vld=%b rdy=%b sum=%h, want %b %b", c, sum_valid, p_ready, sum, ph == 3, ph != 3);
         end
      end
      p_valid = 0; sum_ready = 0;
   endtask

   task automatic test_random();
      int  blocks = 0;
      bit  o;
      int  pi;
      do_reset();
      m_acc = 0; m_ovf = 0; m_cnt = 0; m_out = 0;
      for (int c = 0; c < 600; c++) begin
         clr       = ($urandom_range(0, 29) == 0);
         p_valid   = ($urandom_range(0, 9) < 7);
         p         = 8'($urandom);
         sum_ready = $urandom_range(0, 1);
         pi        = $signed(p);
         if (clr) begin
            m_acc = 0; m_ovf = 0; m_cnt = 0; m_out = 0;
         end else if (!m_out) begin
            if (p_valid) begin
               m_acc = model_add(m_acc, pi, 12, o);
               m_ovf = m_ovf | o;
               m_cnt++;
               if (m_cnt == 4) begin
                  m_out = 1; m_cnt = 0;
               end
            end
         end else if (sum_ready) begin
            m_acc = 0; m_ovf = 0; m_out = 0; blocks++;
         end
         step();
         total++;
         if ({p_ready, sum_valid, sum, ovf} !== {!m_out, m_out, 12'(m_acc), m_ovf}) begin
            bad++;
            $display("FAIL random_cycle%0d: got rdy=%b vld=%b sum=%h ovf=%b, want %b %b %h %b",
                     c, p_ready, sum_valid, sum, ovf, !m_out, m_out, 12'(m_acc), m_ovf);
         end
      end
      clr = 0; p_valid = 0; sum_ready = 0;
      total++;
      if (blocks < 5) begin
         bad++;
         $display("FAIL random_progress: got %0d completed blocks, want at least 5", blocks);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_clr();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
